// File: rtl/multi_insert_fifo_arbiter.sv
// Round-robin, packet-granular arbiter that shares one multi-insert FIFO
// write port between several AXI4-Stream producers. The winner's beats
// pass through combinationally. A packet only starts when the FIFO has
// enough free entries for it.
//
// state  | meaning
// IDLE   | no owner; choose the next source when admission allows
// LOCKED | grant holds the owner; its beats flow until tlast is accepted
module multi_insert_fifo_arbiter #(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FACTOR      = 4,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADMIT_SLOTS = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_SOURCES*FACTOR*DATA_WIDTH-1:0]  s_tdata,
  input  logic [NUM_SOURCES*FACTOR*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_SOURCES-1:0]                    s_tlast,
  input  logic [NUM_SOURCES-1:0]                    s_tvalid,
  output logic [NUM_SOURCES-1:0]                    s_tready,
  output logic [FACTOR*DATA_WIDTH-1:0]              m_tdata,
  output logic [FACTOR*DATA_WIDTH/8-1:0]            m_tkeep,
  output logic                                      m_tlast,
  output logic                                      m_tvalid,
  input  logic                                      m_tready,
  input  logic [$clog2(DEPTH):0]                    filling_level,
  output logic [NUM_SOURCES-1:0]                    grant,
  output logic                                      busy,
  output logic [31:0]                               pkt_count
);

  localparam int unsigned BW = FACTOR * DATA_WIDTH;
  localparam int unsigned KW = BW / 8;
  localparam int unsigned IW = $clog2(NUM_SOURCES);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] ADMIT_MAX = LW'(DEPTH - ADMIT_SLOTS);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state_q;
  logic [NUM_SOURCES-1:0] grant_q;
  logic [IW-1:0]          owner_q;
  logic [IW-1:0]          last_q;
  logic [31:0]            pkt_count_q;

  logic                   admit;
  logic                   locked;
  logic                   hs_last;
  logic                   pick_found;
  logic [IW-1:0]          pick_idx;
  logic [NUM_SOURCES-1:0] grant_d;
  int unsigned            scan_idx;

  assign admit  = (filling_level <= ADMIT_MAX);
  assign locked = (state_q == LOCKED);

  // Round-robin scan starting just after the last finished owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
      scan_idx = (32'(last_q) + i) % NUM_SOURCES;
      if (!pick_found && s_tvalid[IW'(scan_idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(scan_idx);
      end
    end
  end

  // One-hot form of the picked source.
  always_comb begin
    grant_d           = '0;
    grant_d[pick_idx] = 1'b1;
  end

  // Unregistered data path from the owner to the FIFO input.
  always_comb begin
    m_tdata  = s_tdata[owner_q*BW +: BW];
    m_tkeep  = s_tkeep[owner_q*KW +: KW];
    m_tlast  = locked & s_tlast[owner_q];
    m_tvalid = locked & s_tvalid[owner_q];
    s_tready = locked ? (grant_q & {NUM_SOURCES{m_tready}}) : '0;
  end

  assign hs_last = m_tvalid & m_tready & m_tlast;

  // Ownership FSM: admission and arbitration in IDLE, release on tlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      last_q      <= IW'(NUM_SOURCES - 1);
      pkt_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (admit && pick_found) begin
            state_q <= LOCKED;
            grant_q <= grant_d;
            owner_q <= pick_idx;
          end
        end
        LOCKED: begin
          if (hs_last) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= owner_q;
            pkt_count_q <= pkt_count_q + 32'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = locked;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_multi_insert_fifo_arbiter.sv
// Directed bench for multi_insert_fifo_arbiter with default parameters.
// Each source is modelled as a packet generator whose beat data encodes
// {source, beat}. Inputs change 1 ns after the rising edge and outputs are
// sampled 2 ns after it.
module tb_multi_insert_fifo_arbiter;

  localparam int N  = 4;
  localparam int BW = 32;
  localparam int KW = 4;

  logic            clk;
  logic            rst_n;
  logic [N*BW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [BW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic            m_tvalid;
  logic            m_tready;
  logic [6:0]      filling_level;
  logic [N-1:0]    grant;
  logic            busy;
  logic [31:0]     pkt_count;

  int n_cmp;
  int n_bad;

  int beat[N];
  int len[N];
  int pkts_left[N];
  bit gate[N];

  multi_insert_fifo_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_tdata       (s_tdata),
    .s_tkeep       (s_tkeep),
    .s_tlast       (s_tlast),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .m_tdata       (m_tdata),
    .m_tkeep       (m_tkeep),
    .m_tlast       (m_tlast),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .filling_level (filling_level),
    .grant         (grant),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bd(int src, int b);
    logic [7:0] v;
    v = {src[3:0], b[3:0]};
    return {v, v, v, v};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]         = (pkts_left[i] > 0) && gate[i];
      s_tlast[i]          = (beat[i] == len[i] - 1);
      s_tdata[i*BW +: BW] = bd(i, beat[i]);
      s_tkeep[i*KW +: KW] = s_tlast[i] ? 4'(i + 1) : 4'hF;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      beat[i] = 0; len[i] = 1; pkts_left[i] = 0; gate[i] = 1'b1;
    end
  endtask

  task automatic next_cycle();
    logic [N-1:0] hs;
    hs = s_tvalid & s_tready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pkts_left[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    drive_sources();
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_model();
    m_tready = 1'b1;
    filling_level = 7'd0;
    drive_sources();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  localparam bit R_SEQ[6]  = '{1, 0, 0, 1, 1, 1};
  localparam int EB_SEQ[6] = '{0, 1, 1, 1, 2, 3};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clear_model();
    m_tready = 1'b1;
    filling_level = 7'd0;
    drive_sources();
    #2;
    chk("rst_grant",  32'(grant), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_mvalid", 32'(m_tvalid), 0);
    chk("rst_sready", 32'(s_tready), 0);
    chk("rst_pkts",   pkt_count, 0);

    // Sources 0 and 2, three beats each.
    reset_dut();
    pkts_left[0] = 1; len[0] = 3;
    pkts_left[2] = 1; len[2] = 3;
    drive_sources(); #1;
    chk("t1_c0_grant", 32'(grant), 0);
    chk("t1_c0_sready", 32'(s_tready), 0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      chk("t1_s0_grant", 32'(grant), 1);
      chk("t1_s0_valid", 32'(m_tvalid), 1);
      chk("t1_s0_data", m_tdata, bd(0, c - 1));
      chk("t1_s0_last", 32'(m_tlast), (c == 3) ? 1 : 0);
      chk("t1_s0_sready", 32'(s_tready), 1);
    end
    chk("t1_s0_keep", 32'(m_tkeep), 1);
    next_cycle();
    chk("t1_c4_grant", 32'(grant), 0);
    chk("t1_c4_busy", 32'(busy), 0);
    chk("t1_c4_valid", 32'(m_tvalid), 0);
    chk("t1_c4_pkts", pkt_count, 1);
    for (int c = 5; c <= 7; c++) begin
      next_cycle();
      chk("t1_s2_grant", 32'(grant), 4);
      chk("t1_s2_busy", 32'(busy), 1);
      chk("t1_s2_data", m_tdata, bd(2, c - 5));
    end
    next_cycle();
    chk("t1_c8_grant", 32'(grant), 0);
    chk("t1_c8_pkts", pkt_count, 2);

    // All sources valid with single-beat packets.
    reset_dut();
    for (int i = 0; i < N; i++) pkts_left[i] = 3;
    drive_sources(); #1;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      chk("t2_grant", 32'(grant), 1 << (k % 4));
      chk("t2_last", 32'(m_tlast), 1);
      chk("t2_data", m_tdata, bd(k % 4, 0));
      chk("t2_pkts_in", pkt_count, k);
      next_cycle();
      chk("t2_gap", 32'(grant), 0);
      chk("t2_pkts_out", pkt_count, k + 1);
    end

    // Admission threshold.
    reset_dut();
    filling_level = 7'd49;
    pkts_left[1] = 1; len[1] = 2;
    drive_sources(); #1;
    for (int c = 0; c < 3; c++) begin
      chk("t3_full_grant", 32'(grant), 0);
      chk("t3_full_sready", 32'(s_tready), 0);
      next_cycle();
    end
    filling_level = 7'd48; #1;
    chk("t3_48_latency", 32'(grant), 0);
    next_cycle();
    chk("t3_48_grant", 32'(grant), 2);
    chk("t3_48_sready", 32'(s_tready), 2);
    filling_level = 7'd64; #1;
    next_cycle();
    chk("t3_inpkt_grant", 32'(grant), 2);
    chk("t3_inpkt_last", 32'(m_tlast), 1);
    chk("t3_inpkt_data", m_tdata, bd(1, 1));
    next_cycle();
    chk("t3_end_grant", 32'(grant), 0);
    chk("t3_end_pkts", pkt_count, 1);

    // Backpressure on a four-beat packet from source 3.
    reset_dut();
    pkts_left[3] = 1; len[3] = 4;
    drive_sources(); #1;
    next_cycle();
    for (int i = 0; i < 3; i++) pkts_left[i] = 1;
    for (int c = 0; c < 6; c++) begin
      m_tready = R_SEQ[c];
      drive_sources(); #1;
      chk("t4_grant", 32'(grant), 8);
      chk("t4_sready", 32'(s_tready), R_SEQ[c] ? 8 : 0);
      chk("t4_data", m_tdata, bd(3, EB_SEQ[c]));
      chk("t4_last", 32'(m_tlast), (EB_SEQ[c] == 3) ? 1 : 0);
      next_cycle();
    end
    chk("t4_end_grant", 32'(grant), 0);
    chk("t4_end_busy", 32'(busy), 0);
    next_cycle();
    chk("t4_next_grant", 32'(grant), 1);

    // Owner drops tvalid mid-packet while another source waits.
    reset_dut();
    pkts_left[1] = 1; len[1] = 3;
    drive_sources(); #1;
    next_cycle();
    chk("t5_grant", 32'(grant), 2);
    chk("t5_b0", m_tdata, bd(1, 0));
    next_cycle();
    pkts_left[0] = 1; gate[1] = 1'b0;
    drive_sources(); #1;
    for (int c = 0; c < 2; c++) begin
      chk("t5_hold_grant", 32'(grant), 2);
      chk("t5_hold_valid", 32'(m_tvalid), 0);
      chk("t5_hold_sready", 32'(s_tready), 2);
      next_cycle();
    end
    gate[1] = 1'b1;
    drive_sources(); #1;
    chk("t5_b1", m_tdata, bd(1, 1));
    chk("t5_b1_valid", 32'(m_tvalid), 1);
    next_cycle();
    chk("t5_b2", m_tdata, bd(1, 2));
    chk("t5_b2_last", 32'(m_tlast), 1);
    next_cycle();
    chk("t5_gap", 32'(grant), 0);
    next_cycle();
    chk("t5_s0_grant", 32'(grant), 1);

    // Asynchronous reset in the middle of a packet.
    reset_dut();
    pkts_left[0] = 2; len[0] = 2;
    drive_sources(); #1;
    for (int c = 0; c < 4; c++) next_cycle();
    chk("t6_pre_grant", 32'(grant), 1);
    chk("t6_pre_pkts", pkt_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_valid", 32'(m_tvalid), 0);
    chk("t6_rst_pkts", pkt_count, 0);
    chk("t6_rst_busy", 32'(busy), 0);
    clear_model();
    pkts_left[0] = 1;
    pkts_left[1] = 1;
    drive_sources();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("t6_rel_grant", 32'(grant), 0);
    next_cycle();
    chk("t6_first_grant", 32'(grant), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
